// File: rtl/iic_cfg_sequencer_if.sv
// Request/done handshake bundle between the configuration sequencer and the IIC driver.
// The sequencer owns the master side; the driver (or its model) owns the slave side.
interface iic_cfg_sequencer_if;
    logic [15:0] drv_slave;
    logic [7:0]  drv_wdata;
    logic        drv_wr_req;
    logic        drv_wr_done;
    logic        drv_rd_req;
    logic        drv_rd_done;
    logic [7:0]  drv_rd_data;

    modport master (
        output drv_slave, drv_wdata, drv_wr_req, drv_rd_req,
        input  drv_wr_done, drv_rd_done, drv_rd_data
    );

    modport slave (
        input  drv_slave, drv_wdata, drv_wr_req, drv_rd_req,
        output drv_wr_done, drv_rd_done, drv_rd_data
    );
endinterface

// File: rtl/iic_cfg_sequencer.sv
// IIC configuration sequencer and arbiter.
// Walks an external register table after a start pulse, writing every entry through the
// IIC driver and optionally reading it back for verification. After a clean walk the
// driver is handed to a single user request port for ad-hoc reads and writes.
module iic_cfg_sequencer #(
    parameter int TBL_AW      = 4,
    parameter bit VERIFY      = 1'b1,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              start,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [23:0]       tbl_data,
    output logic              init_busy,
    output logic              init_done,
    output logic              init_err,
    output logic [TBL_AW-1:0] err_idx,
    input  logic              usr_req,
    input  logic              usr_rnw,
    input  logic [15:0]       usr_addr,
    input  logic [7:0]        usr_wdata,
    output logic              usr_ack,
    output logic [7:0]        usr_rdata,
    iic_cfg_sequencer_if.master drv
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WR, S_GAP, S_RD, S_CHK, S_NEXT, S_DONE,
        S_SERVE, S_UWR, S_URD, S_UACK, S_UGAP
    } state_t;

    localparam int                TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TBL_AW-1:0] ADDR_LAST = '1;
    localparam logic [23:0]       TERM      = 24'hFFFFFF;
    localparam logic [7:0]        TMO_DATA  = 8'hEE;

    state_t            state_q, state_d;
    logic [TBL_AW-1:0] tbl_addr_q, tbl_addr_d;
    logic              init_busy_q, init_busy_d;
    logic              init_done_q, init_done_d;
    logic              init_err_q, init_err_d;
    logic [TBL_AW-1:0] err_idx_q, err_idx_d;
    logic [15:0]       slave_q, slave_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              wr_req_q, wr_req_d;
    logic              rd_req_q, rd_req_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              usr_ack_q, usr_ack_d;
    logic [7:0]        usr_rdata_q, usr_rdata_d;

    logic wr_done_ok;
    logic rd_done_ok;
    logic tmo_hit;

    // A done pulse only counts while its own request is being held.
    assign wr_done_ok = drv.drv_wr_done && wr_req_q;
    assign rd_done_ok = drv.drv_rd_done && rd_req_q;
    assign tmo_hit    = (tmr_q == TMO_LAST);

    // State register and all registered outputs; reset drops the driver requests at once.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tbl_addr_q  <= '0;
            init_busy_q <= 1'b0;
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
            err_idx_q   <= '0;
            slave_q     <= '0;
            wdata_q     <= '0;
            rd_data_q   <= '0;
            wr_req_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            tmr_q       <= '0;
            usr_ack_q   <= 1'b0;
            usr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            tbl_addr_q  <= tbl_addr_d;
            init_busy_q <= init_busy_d;
            init_done_q <= init_done_d;
            init_err_q  <= init_err_d;
            err_idx_q   <= err_idx_d;
            slave_q     <= slave_d;
            wdata_q     <= wdata_d;
            rd_data_q   <= rd_data_d;
            wr_req_q    <= wr_req_d;
            rd_req_q    <= rd_req_d;
            tmr_q       <= tmr_d;
            usr_ack_q   <= usr_ack_d;
            usr_rdata_q <= usr_rdata_d;
        end
    end

    // Next-state logic: table walk, verification, user service and done-timeout handling.
    always_comb begin
        state_d     = state_q;
        tbl_addr_d  = tbl_addr_q;
        init_busy_d = init_busy_q;
        init_done_d = init_done_q;
        init_err_d  = init_err_q;
        err_idx_d   = err_idx_q;
        slave_d     = slave_q;
        wdata_d     = wdata_q;
        rd_data_d   = rd_data_q;
        usr_rdata_d = usr_rdata_q;
        usr_ack_d   = 1'b0;
        tmr_d       = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_FETCH;
                    tbl_addr_d  = '0;
                    init_busy_d = 1'b1;
                    init_done_d = 1'b0;
                    init_err_d  = 1'b0;
                end
            end
            S_FETCH: begin
                if (tbl_data == TERM) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WR;
                    slave_d = tbl_data[23:8];
                    wdata_d = tbl_data[7:0];
                end
            end
            S_WR: begin
                if (wr_done_ok) begin
                    state_d = S_GAP;
                end else if (tmo_hit) begin
                    state_d     = S_IDLE;
                    init_err_d  = 1'b1;
                    err_idx_d   = tbl_addr_q;
                    init_busy_d = 1'b0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_GAP: begin
                state_d = VERIFY ? S_RD : S_NEXT;
            end
            S_RD: begin
                if (rd_done_ok) begin
                    state_d   = S_CHK;
                    rd_data_d = drv.drv_rd_data;
                end else if (tmo_hit) begin
                    state_d     = S_IDLE;
                    init_err_d  = 1'b1;
                    err_idx_d   = tbl_addr_q;
                    init_busy_d = 1'b0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_CHK: begin
                // wdata_q still holds the entry's data byte while the read-back is compared.
                if (rd_data_q != wdata_q) begin
                    state_d     = S_IDLE;
                    init_err_d  = 1'b1;
                    err_idx_d   = tbl_addr_q;
                    init_busy_d = 1'b0;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (tbl_addr_q == ADDR_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_FETCH;
                    tbl_addr_d = tbl_addr_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d     = S_SERVE;
                init_busy_d = 1'b0;
                init_done_d = 1'b1;
            end
            S_SERVE: begin
                if (start) begin
                    state_d     = S_FETCH;
                    tbl_addr_d  = '0;
                    init_busy_d = 1'b1;
                    init_done_d = 1'b0;
                    init_err_d  = 1'b0;
                end else if (usr_req) begin
                    state_d = usr_rnw ? S_URD : S_UWR;
                    slave_d = usr_addr;
                    wdata_d = usr_wdata;
                end
            end
            S_UWR: begin
                if (wr_done_ok) begin
                    state_d   = S_UACK;
                    usr_ack_d = 1'b1;
                end else if (tmo_hit) begin
                    state_d     = S_IDLE;
                    usr_ack_d   = 1'b1;
                    usr_rdata_d = TMO_DATA;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_URD: begin
                if (rd_done_ok) begin
                    state_d     = S_UACK;
                    usr_ack_d   = 1'b1;
                    usr_rdata_d = drv.drv_rd_data;
                end else if (tmo_hit) begin
                    state_d     = S_IDLE;
                    usr_ack_d   = 1'b1;
                    usr_rdata_d = TMO_DATA;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_UACK: begin
                state_d = S_UGAP;
            end
            S_UGAP: begin
                state_d = S_SERVE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Requests are registered images of the next state, so they are never high together.
        wr_req_d = (state_d == S_WR) || (state_d == S_UWR);
        rd_req_d = (state_d == S_RD) || (state_d == S_URD);
    end

    assign tbl_addr      = tbl_addr_q;
    assign init_busy     = init_busy_q;
    assign init_done     = init_done_q;
    assign init_err      = init_err_q;
    assign err_idx       = err_idx_q;
    assign usr_ack       = usr_ack_q;
    assign usr_rdata     = usr_rdata_q;
    assign drv.drv_slave  = slave_q;
    assign drv.drv_wdata  = wdata_q;
    assign drv.drv_wr_req = wr_req_q;
    assign drv.drv_rd_req = rd_req_q;

endmodule

// File: tb/tb_iic_cfg_sequencer.sv
// Directed bench for iic_cfg_sequencer: table walk, verify error and retry, timeout,
// user service arbitration and asynchronous reset during a transfer.
module tb_iic_cfg_sequencer;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  tbl_addr;
    logic [23:0] tbl_data;
    logic        init_busy, init_done, init_err;
    logic [3:0]  err_idx;
    logic        usr_req, usr_rnw;
    logic [15:0] usr_addr;
    logic [7:0]  usr_wdata;
    logic        usr_ack;
    logic [7:0]  usr_rdata;

    iic_cfg_sequencer_if drv_if ();

    always #5 sys_clk = ~sys_clk;

    iic_cfg_sequencer #(
        .TBL_AW      (4),
        .VERIFY      (1'b1),
        .TIMEOUT_CYC (100)
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .start     (start),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data),
        .init_busy (init_busy),
        .init_done (init_done),
        .init_err  (init_err),
        .err_idx   (err_idx),
        .usr_req   (usr_req),
        .usr_rnw   (usr_rnw),
        .usr_addr  (usr_addr),
        .usr_wdata (usr_wdata),
        .usr_ack   (usr_ack),
        .usr_rdata (usr_rdata),
        .drv       (drv_if.master)
    );

    // External register table, combinational read.
    logic [23:0] tbl [0:15];
    assign tbl_data = tbl[tbl_addr];

    // Driver model: done pulse 3 cycles after req, writes stored, reads echo memory.
    bit          no_done   = 1'b0;
    bit          force_rd  = 1'b0;
    logic [7:0]  force_val = 8'h00;
    bit          bad_en    = 1'b0;
    logic [15:0] bad_addr  = 16'h0000;
    bit   [7:0]  mem [0:65535];
    int          log_q[$];
    int          wcnt = 0;
    int          rcnt = 0;
    int          ack_cnt = 0;

    always @(posedge sys_clk) begin
        drv_if.drv_wr_done <= 1'b0;
        drv_if.drv_rd_done <= 1'b0;
        if (drv_if.drv_wr_req === 1'b1 && drv_if.drv_wr_done !== 1'b1 && !no_done) begin
            if (wcnt == 2) begin
                drv_if.drv_wr_done <= 1'b1;
                mem[drv_if.drv_slave] <= drv_if.drv_wdata;
                log_q.push_back({16'h0000, drv_if.drv_slave});
                wcnt <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end
        if (drv_if.drv_rd_req === 1'b1 && drv_if.drv_rd_done !== 1'b1 && !no_done) begin
            if (rcnt == 2) begin
                drv_if.drv_rd_done <= 1'b1;
                if (force_rd)
                    drv_if.drv_rd_data <= force_val;
                else if (bad_en && drv_if.drv_slave == bad_addr)
                    drv_if.drv_rd_data <= 8'h00;
                else
                    drv_if.drv_rd_data <= mem[drv_if.drv_slave];
                log_q.push_back({16'h0001, drv_if.drv_slave});
                rcnt <= 0;
            end else begin
                rcnt <= rcnt + 1;
            end
        end
    end

    // Count user acknowledge pulses.
    always @(posedge sys_clk) begin
        if (usr_ack === 1'b1) ack_cnt <= ack_cnt + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int log_at(input int idx);
        if (idx < log_q.size()) return log_q[idx];
        return -1;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge sys_clk);
            if (init_done === 1'b1 || init_err === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge sys_clk);
            if (usr_ack === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_wr_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge sys_clk);
            if (drv_if.drv_wr_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int n0, n1, a0, gap, hi;

        rst = 1'b1; start = 1'b0;
        usr_req = 1'b0; usr_rnw = 1'b0; usr_addr = 16'h0; usr_wdata = 8'h0;
        for (int i = 0; i < 16; i++) tbl[i] = 24'hFFFFFF;
        tbl[0] = 24'h12345A;
        tbl[1] = 24'h1235A5;
        cyc(3);

        // Reset state
        chk("rst_busy", init_busy, 0);
        chk("rst_done", init_done, 0);
        chk("rst_err", init_err, 0);
        chk("rst_addr", tbl_addr, 0);
        chk("rst_wrreq", drv_if.drv_wr_req, 0);
        chk("rst_ack", usr_ack, 0);
        rst = 1'b0;
        cyc(1);

        // User request before init is never acknowledged
        a0 = ack_cnt;
        usr_req = 1'b1; usr_rnw = 1'b1; usr_addr = 16'h1234;
        cyc(20);
        chk("preinit_ack", ack_cnt - a0, 0);
        chk("preinit_log", log_q.size(), 0);
        usr_req = 1'b0;

        // Normal table walk with verify
        n0 = log_q.size();
        pulse_start();
        chk("init_busy_on", init_busy, 1);
        wait_end(ok);
        chk("init_wait", ok, 1);
        chk("init_done", init_done, 1);
        chk("init_err", init_err, 0);
        chk("init_busy_off", init_busy, 0);
        chk("init_tbl_addr", tbl_addr, 2);
        chk("init_nops", log_q.size() - n0, 4);
        chk("init_op0", log_at(n0), 32'h0000_1234);
        chk("init_op1", log_at(n0 + 1), 32'h0001_1234);
        chk("init_op2", log_at(n0 + 2), 32'h0000_1235);
        chk("init_op3", log_at(n0 + 3), 32'h0001_1235);

        // User read, held request: second transaction waits at least 2 cycles after ack
        force_rd = 1'b1; force_val = 8'h3C;
        a0 = ack_cnt;
        usr_rnw = 1'b1; usr_addr = 16'h1234; usr_req = 1'b1;
        wait_ack(ok);
        chk("urd_ack_wait", ok, 1);
        chk("urd_rdata", usr_rdata, 8'h3C);
        chk("urd_log", log_at(log_q.size() - 1), 32'h0001_1234);
        @(negedge sys_clk);
        chk("urd_ack_1cyc", usr_ack, 0);
        gap = 1;
        while (drv_if.drv_rd_req !== 1'b1 && gap < 50) begin
            @(negedge sys_clk);
            gap++;
        end
        chk("urd_gap_ge2", (gap >= 2 && gap < 50), 1);
        wait_ack(ok);
        usr_req = 1'b0;
        chk("urd2_ack_wait", ok, 1);
        cyc(10);
        chk("urd_ack_cnt", ack_cnt - a0, 2);
        force_rd = 1'b0;

        // User write
        usr_rnw = 1'b0; usr_addr = 16'h0042; usr_wdata = 8'h77; usr_req = 1'b1;
        wait_ack(ok);
        usr_req = 1'b0;
        chk("uwr_ack_wait", ok, 1);
        chk("uwr_mem", mem[16'h0042], 8'h77);
        chk("uwr_log", log_at(log_q.size() - 1), 32'h0000_0042);
        chk("uwr_rdata_held", usr_rdata, 8'h3C);
        cyc(3);

        // start and usr_req together in SERVE: start wins, user served after re-init
        n0 = log_q.size();
        start = 1'b1;
        usr_req = 1'b1; usr_rnw = 1'b0; usr_addr = 16'h0050; usr_wdata = 8'h11;
        @(negedge sys_clk);
        start = 1'b0;
        chk("race_done_low", init_done, 0);
        chk("race_busy", init_busy, 1);
        wait_ack(ok);
        usr_req = 1'b0;
        chk("race_ack_wait", ok, 1);
        chk("race_done_at_ack", init_done, 1);
        chk("race_nops", log_q.size() - n0, 5);
        chk("race_first", log_at(n0), 32'h0000_1234);
        chk("race_user", log_at(n0 + 4), 32'h0000_0050);
        chk("race_mem", mem[16'h0050], 8'h11);
        cyc(3);

        // Verify mismatch on the second entry
        bad_en = 1'b1; bad_addr = 16'h1235;
        n0 = log_q.size();
        pulse_start();
        wait_end(ok);
        chk("vfy_wait", ok, 1);
        chk("vfy_err", init_err, 1);
        chk("vfy_err_idx", err_idx, 1);
        chk("vfy_done", init_done, 0);
        chk("vfy_busy", init_busy, 0);
        n1 = log_q.size();
        cyc(20);
        chk("vfy_no_more", log_q.size() - n1, 0);
        chk("vfy_nops", n1 - n0, 4);

        // Retry from index 0
        bad_en = 1'b0;
        n0 = log_q.size();
        pulse_start();
        wait_end(ok);
        chk("retry_wait", ok, 1);
        chk("retry_done", init_done, 1);
        chk("retry_err", init_err, 0);
        chk("retry_first", log_at(n0), 32'h0000_1234);
        chk("retry_nops", log_q.size() - n0, 4);
        cyc(3);

        // Driver never answers: request held exactly TIMEOUT_CYC cycles
        no_done = 1'b1;
        pulse_start();
        wait_wr_req(ok);
        chk("tmo_req_seen", ok, 1);
        hi = 0;
        while (drv_if.drv_wr_req === 1'b1 && hi < 300) begin
            hi++;
            @(negedge sys_clk);
        end
        chk("tmo_req_cycles", hi, 100);
        chk("tmo_err", init_err, 1);
        chk("tmo_err_idx", err_idx, 0);
        chk("tmo_busy", init_busy, 0);
        chk("tmo_done", init_done, 0);

        // Asynchronous reset during a write
        pulse_start();
        wait_wr_req(ok);
        chk("arst_req_seen", ok, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wrreq", drv_if.drv_wr_req, 0);
        chk("arst_rdreq", drv_if.drv_rd_req, 0);
        chk("arst_busy", init_busy, 0);
        chk("arst_err", init_err, 0);
        chk("arst_done", init_done, 0);
        chk("arst_addr", tbl_addr, 0);
        @(negedge sys_clk);
        rst = 1'b0;
        no_done = 1'b0;
        cyc(1);
        n0 = log_q.size();
        pulse_start();
        wait_end(ok);
        chk("clean_wait", ok, 1);
        chk("clean_done", init_done, 1);
        chk("clean_err", init_err, 0);
        chk("clean_nops", log_q.size() - n0, 4);
        chk("clean_first", log_at(n0), 32'h0000_1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
